// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Holds the address/data widths and register count used by regfile and
// reg_scoreboard, the writeback request struct, and a small helper that
// tells whether an address names a real, writable register (x0 never is).
package regfile_pkg;

  // Sizes are given as MSB indices: a 5-bit address and a 32-bit word.
  localparam int REG_ADDR_SIZE = 4;
  localparam int REG_DATA_SIZE = 31;
  localparam int REG_NUM       = 1 << (REG_ADDR_SIZE + 1);

  typedef logic [REG_ADDR_SIZE:0] reg_addr_t;
  typedef logic [REG_DATA_SIZE:0] reg_data_t;

  // One writeback request per cycle.
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  // x0 is hardwired to zero, so it can neither be written nor be pending.
  function automatic logic addr_live(input reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-result scoreboard for the register file.
// One bit per architectural register; a bit is set when decode issues an
// instruction that will write that register and cleared when writeback
// commits it. Bit 0 is never set.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_set_en/i_set_addr mark a destination pending
//   i_clr_en/i_clr_addr writeback clears a destination
//   i_flush             drop every pending mark (beats a same-edge set)
//   i_lk1_addr/o_lk1_pend, i_lk2_addr/o_lk2_pend
//                       combinational lookups of the registered vector
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_set_en,
  input  reg_addr_t i_set_addr,
  input  logic      i_clr_en,
  input  reg_addr_t i_clr_addr,
  input  logic      i_flush,
  input  reg_addr_t i_lk1_addr,
  output logic      o_lk1_pend,
  input  reg_addr_t i_lk2_addr,
  output logic      o_lk2_pend
);

  logic [REG_NUM-1:0] r_pend;
  logic [REG_NUM-1:0] w_pend_nxt;

  // Clear first, then set: when the same register is both retired and
  // re-issued on one edge, the newer producer keeps it pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr_en && addr_live(i_clr_addr)) w_pend_nxt[i_clr_addr] = 1'b0;
    if (i_set_en && addr_live(i_set_addr)) w_pend_nxt[i_set_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) r_pend <= '0;
    else                  r_pend <= w_pend_nxt;
  end

  assign o_lk1_pend = r_pend[i_lk1_addr];
  assign o_lk2_pend = r_pend[i_lk2_addr];

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file with two combinational read ports, one
// writeback port with same-cycle bypass, and a pending-write scoreboard
// that decode uses to stall on RAW hazards.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   rs1_addr/rs1_data/rs1_busy  read port 1 and its hazard flag
//   rs2_addr/rs2_data/rs2_busy  read port 2 and its hazard flag
//   wr_en/wr_addr/wr_data       writeback port (x0 writes discarded)
//   sb_set_en/sb_set_addr       decode marks a destination pending
//   flush                       drop all pending marks
module regfile
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_SIZE:0] rs1_addr,
  output logic [REG_DATA_SIZE:0] rs1_data,
  input  logic [REG_ADDR_SIZE:0] rs2_addr,
  output logic [REG_DATA_SIZE:0] rs2_data,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  input  logic                   wr_en,
  input  logic [REG_ADDR_SIZE:0] wr_addr,
  input  logic [REG_DATA_SIZE:0] wr_data,
  input  logic                   sb_set_en,
  input  logic [REG_ADDR_SIZE:0] sb_set_addr,
  input  logic                   flush
);

  wb_req_t   w_wb;
  logic      w_wr_commit;
  logic      w_byp1, w_byp2;
  logic      w_pend1, w_pend2;
  reg_data_t r_regs [REG_NUM];

  assign w_wb        = '{en: wr_en, addr: wr_addr, data: wr_data};
  assign w_wr_commit = w_wb.en && addr_live(w_wb.addr);

  // Storage. Entry 0 is only ever cleared; reads of x0 are forced to 0
  // below anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (w_wr_commit) begin
      r_regs[w_wb.addr] <= w_wb.data;
    end
  end

`ifdef SIMULATE
  always @(posedge clk) begin
    if (!reset && w_wr_commit)
      $display("%0t regfile write x%0d = 0x%08h", $time, w_wb.addr, w_wb.data);
  end
`endif

  // A same-cycle write to the addressed register is forwarded, so the
  // consumer never has to wait an extra cycle for writeback.
  assign w_byp1 = w_wr_commit && (w_wb.addr == rs1_addr);
  assign w_byp2 = w_wr_commit && (w_wb.addr == rs2_addr);

  // While reset is asserted the array may not be cleared yet, so the
  // stored path is masked; bypass still forwards the live write.
  always_comb begin
    rs1_data = '0;
    if (w_byp1)                               rs1_data = w_wb.data;
    else if (!reset && addr_live(rs1_addr))   rs1_data = r_regs[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (w_byp2)                               rs2_data = w_wb.data;
    else if (!reset && addr_live(rs2_addr))   rs2_data = r_regs[rs2_addr];
  end

  reg_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (sb_set_en),
    .i_set_addr (sb_set_addr),
    .i_clr_en   (w_wr_commit),
    .i_clr_addr (w_wb.addr),
    .i_flush    (flush),
    .i_lk1_addr (rs1_addr),
    .o_lk1_pend (w_pend1),
    .i_lk2_addr (rs2_addr),
    .o_lk2_pend (w_pend2)
  );

  // A write landing this cycle resolves the hazard through the bypass.
  // The scoreboard never holds bit 0, so x0 is never busy.
  assign rs1_busy = !reset && w_pend1 && !w_byp1;
  assign rs2_busy = !reset && w_pend2 && !w_byp2;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  regfile dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_addr    (rs1_addr),
    .rs1_data    (rs1_data),
    .rs2_addr    (rs2_addr),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  initial begin
    idle();
    rs1_addr = '0; rs2_addr = '0;
    reset = 1'b1;
    #1;
    tick();
    // During reset: busy forced low, stored data masked.
    rd(5'd3, 5'd4);
    chk("rst_busy1", {31'b0, rs1_busy}, 32'h0);
    chk("rst_data2", rs2_data, 32'h0);
    tick();
    idle();

    // Every address reads 0 / not busy after reset.
    for (int a = 0; a < 32; a++) begin
      rd(a[4:0], 5'(31 - a));
      chk("init_d1", rs1_data, 32'h0);
      chk("init_d2", rs2_data, 32'h0);
      chk("init_b", {30'b0, rs1_busy, rs2_busy}, 32'h0);
    end

    // Basic write/read and x0 immutability.
    wr(5'd5, 32'hDEADBEEF); tick(); idle();
    rd(5'd5, 5'd0);
    chk("x5_rd", rs1_data, 32'hDEADBEEF);
    chk("x0_rd", rs2_data, 32'h0);
    wr(5'd0, 32'h1234); rd(5'd0, 5'd0);
    chk("x0_nobyp", rs1_data, 32'h0);
    tick(); idle(); rd(5'd0, 5'd5);
    chk("x0_after", rs1_data, 32'h0);
    chk("x5_keep", rs2_data, 32'hDEADBEEF);

    // Bypass on both ports, then independent bypass.
    wr(5'd7, 32'h1); tick(); idle();
    wr(5'd7, 32'hA5A5A5A5); rd(5'd7, 5'd7);
    chk("byp1", rs1_data, 32'hA5A5A5A5);
    chk("byp2", rs2_data, 32'hA5A5A5A5);
    tick(); idle(); rd(5'd7, 5'd7);
    chk("x7_commit", rs1_data, 32'hA5A5A5A5);
    wr(5'd7, 32'h0F0F0F0F); rd(5'd5, 5'd7);
    chk("byp_ind1", rs1_data, 32'hDEADBEEF);
    chk("byp_ind2", rs2_data, 32'h0F0F0F0F);
    tick(); idle();

    // Scoreboard set / release by writeback.
    sb_set_en = 1'b1; sb_set_addr = 5'd3; tick(); idle();
    rd(5'd3, 5'd0);
    chk("sb3_busy", {31'b0, rs1_busy}, 32'h1);
    wr(5'd3, 32'h55); rd(5'd3, 5'd0);
    chk("sb3_rel", {31'b0, rs1_busy}, 32'h0);
    chk("sb3_byp", rs1_data, 32'h55);
    tick(); idle(); rd(5'd3, 5'd0);
    chk("sb3_clr", {31'b0, rs1_busy}, 32'h0);
    chk("sb3_data", rs1_data, 32'h55);

    // Same-edge set and clear of one register: set wins.
    sb_set_en = 1'b1; sb_set_addr = 5'd9; wr(5'd9, 32'h77); tick(); idle();
    rd(5'd0, 5'd9);
    chk("x9_data", rs2_data, 32'h77);
    chk("x9_busy", {31'b0, rs2_busy}, 32'h1);
    // Same again with flush: write commits, nothing pending.
    sb_set_en = 1'b1; sb_set_addr = 5'd9; wr(5'd9, 32'h88); flush = 1'b1;
    tick(); idle(); rd(5'd0, 5'd9);
    chk("x9f_data", rs2_data, 32'h88);
    chk("x9f_busy", {31'b0, rs2_busy}, 32'h0);

    // Set and clear of different registers both land.
    sb_set_en = 1'b1; sb_set_addr = 5'd10; tick(); idle();
    sb_set_en = 1'b1; sb_set_addr = 5'd11; wr(5'd10, 32'hAB); tick(); idle();
    rd(5'd10, 5'd11);
    chk("diff_clr", {31'b0, rs1_busy}, 32'h0);
    chk("diff_set", {31'b0, rs2_busy}, 32'h1);
    chk("diff_data", rs1_data, 32'hAB);
    // Flush alone clears x11 and beats a same-edge set of x12.
    sb_set_en = 1'b1; sb_set_addr = 5'd12; flush = 1'b1; tick(); idle();
    rd(5'd11, 5'd12);
    chk("flush_b", {30'b0, rs1_busy, rs2_busy}, 32'h0);

    // x0 never goes busy.
    sb_set_en = 1'b1; sb_set_addr = 5'd0; tick(); idle();
    rd(5'd0, 5'd0);
    chk("x0_busy", {30'b0, rs1_busy, rs2_busy}, 32'h0);

    // Reset overrides a same-cycle write and set, and clears prior state.
    sb_set_en = 1'b1; sb_set_addr = 5'd13; tick(); idle();
    sb_set_en = 1'b1; sb_set_addr = 5'd4; wr(5'd6, 32'h99); reset = 1'b1;
    tick(); idle();
    rd(5'd4, 5'd6);
    chk("rst_b4", {31'b0, rs1_busy}, 32'h0);
    chk("rst_x6", rs2_data, 32'h0);
    rd(5'd13, 5'd5);
    chk("rst_b13", {31'b0, rs1_busy}, 32'h0);
    chk("rst_x5", rs2_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
